// File: rtl/miner_pkg.sv
// miner_pkg: shared constants, FSM state type and result record for the
// miner work scheduler.
package miner_pkg;

  localparam int unsigned WORK_BYTES   = 64;
  localparam int unsigned RESULT_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    HASH,
    EXHAUSTED
  } state_t;

  typedef struct packed {
    logic [31:0] nonce;
    logic [31:0] job;
  } result_t;

  // Byte idx of a result record in wire order: nonce LSB first, then job LSB first.
  function automatic logic [7:0] result_byte(input result_t r, input logic [2:0] idx);
    logic [63:0] w;
    w = {r.job, r.nonce} >> {idx, 3'b000};
    return w[7:0];
  endfunction

endpackage

// File: rtl/miner_work_scheduler_result_fifo.sv
// result_fifo: synchronous show-ahead FIFO with full/empty flags.
// A write into a full FIFO is accepted when a read happens in the same cycle.
module result_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, contents need no reset
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/miner_work_scheduler.sv
// miner_work_scheduler: assembles 64-byte work frames, commits them to the
// hash core, sequences the nonce and serialises golden-nonce result records.
// Build option: define MINER_STALE_DROP_EN to discard golden strobes for
// PIPE_DEPTH clk after every commit.
module miner_work_scheduler
  import miner_pkg::*;
#(
  parameter int unsigned NONCE_STEP = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PIPE_DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         rx_frame,
  output logic [255:0] core_midstate,
  output logic [255:0] core_data,
  output logic [31:0]  core_nonce,
  output logic         core_run,
  input  logic         core_golden_valid,
  input  logic [31:0]  core_golden_nonce,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [31:0]  job_id,
  output logic         exhausted,
  output logic         fifo_overflow
);

  localparam logic [6:0] CNT_FULL = 7'(WORK_BYTES);
  localparam logic [6:0] CNT_SAT  = 7'(WORK_BYTES + 1);

  // Receive path
  logic [6:0]   rx_cnt_q, rx_cnt_d, cnt_eff;
  logic [511:0] shadow_q, shadow_eff;
  logic         commit;

  // Committed work
  logic [255:0] midstate_q, data_q;
  logic [31:0]  job_q;

  // Nonce sequencer
  state_t       state_q;
  logic [31:0]  nonce_q;
  logic         run_q, exh_q;
  logic [32:0]  nonce_sum;

  // Result capture and serialiser
  logic         golden_take;
  logic         fifo_full, fifo_empty, pop;
  logic [63:0]  fifo_rd;
  logic         ovf_q;
  logic         tx_valid_q, tx_valid_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic [2:0]   idx_q, idx_d;
  result_t      rec_q, rec_d;

  // A byte arriving with the frame strobe is counted before the strobe is judged
  always_comb begin
    cnt_eff    = rx_cnt_q;
    shadow_eff = shadow_q;
    if (rx_valid) begin
      shadow_eff = {shadow_q[503:0], rx_byte};
      if (rx_cnt_q != CNT_SAT) cnt_eff = rx_cnt_q + 7'd1;
    end
    commit   = rx_frame && (cnt_eff == CNT_FULL);
    rx_cnt_d = rx_frame ? '0 : cnt_eff;
  end

  // Shadow buffer and byte counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt_q <= '0;
      shadow_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      shadow_q <= shadow_eff;
    end
  end

  // Atomic commit of a complete frame to the core
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      midstate_q <= '0;
      data_q     <= '0;
      job_q      <= '0;
    end else if (commit) begin
      midstate_q <= shadow_eff[511:256];
      data_q     <= shadow_eff[255:0];
      job_q      <= job_q + 32'd1;
    end
  end

  assign nonce_sum = {1'b0, nonce_q} + 33'(NONCE_STEP);

  // Nonce FSM: a carry out of the next addition means the current nonce was the last
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      nonce_q <= '0;
      run_q   <= 1'b0;
      exh_q   <= 1'b0;
    end else if (commit) begin
      state_q <= HASH;
      nonce_q <= '0;
      run_q   <= 1'b1;
      exh_q   <= 1'b0;
    end else begin
      case (state_q)
        HASH: begin
          if (nonce_sum[32]) begin
            state_q <= EXHAUSTED;
            run_q   <= 1'b0;
            exh_q   <= 1'b1;
          end else begin
            nonce_q <= nonce_sum[31:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MINER_STALE_DROP_EN
  localparam int unsigned SW = $clog2(PIPE_DEPTH + 1);
  logic [SW-1:0] stale_q;

  // Stale window counter, reloaded on every commit
  always_ff @(posedge clk) begin
    if (!rst_n)               stale_q <= '0;
    else if (commit)          stale_q <= SW'(PIPE_DEPTH);
    else if (stale_q != '0)   stale_q <= stale_q - 1'b1;
  end

  assign golden_take = core_golden_valid && (stale_q == '0);
`else
  localparam int unsigned unused_pipe_depth = PIPE_DEPTH;
  assign golden_take = core_golden_valid;
`endif

  result_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (golden_take),
    .wr_data_i ({core_golden_nonce, job_q}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Sticky drop flag; a same-cycle pop makes room so nothing is lost then
  always_ff @(posedge clk) begin
    if (!rst_n)                                    ovf_q <= 1'b0;
    else if (golden_take && fifo_full && !pop)     ovf_q <= 1'b1;
  end

  // Serialiser next state: pop when idle, advance one byte per handshake
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    idx_d      = idx_q;
    rec_d      = rec_q;
    pop        = 1'b0;
    if (!tx_valid_q) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        rec_d      = fifo_rd;
        idx_d      = '0;
        tx_valid_d = 1'b1;
        tx_byte_d  = result_byte(fifo_rd, 3'd0);
      end
    end else if (tx_ready) begin
      if (idx_q == 3'(RESULT_BYTES - 1)) begin
        tx_valid_d = 1'b0;
      end else begin
        idx_d     = idx_q + 3'd1;
        tx_byte_d = result_byte(rec_q, idx_q + 3'd1);
      end
    end
  end

  // Serialiser registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      idx_q      <= '0;
      rec_q      <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
      idx_q      <= idx_d;
      rec_q      <= rec_d;
    end
  end

  assign core_midstate = midstate_q;
  assign core_data     = data_q;
  assign core_nonce    = nonce_q;
  assign core_run      = run_q;
  assign job_id        = job_q;
  assign exhausted     = exh_q;
  assign fifo_overflow = ovf_q;
  assign tx_valid      = tx_valid_q;
  assign tx_byte       = tx_byte_q;

endmodule

// File: tb/tb_miner_work_scheduler.sv
// tb_miner_work_scheduler: self-checking bench for miner_work_scheduler.
// A second instance with a large NONCE_STEP reaches nonce-space exhaustion
// in a few cycles. Honours MINER_STALE_DROP_EN in its reference model.
module tb_miner_work_scheduler;

  localparam int unsigned PIPE  = 64;
  localparam int unsigned XSTEP = 32'h4000_0000;
  localparam logic [255:0] MID  = 256'h2b3f8126_9a7c1e04_5d63f2a8_c0e17b39_4f8a6d21_e5b0c3d7_18f4a962_2619c0b5;
  localparam logic [255:0] DAT  = 256'h00000000_00000000_00000000_80000000_00000000_39f3001b_6b7b8d4d_c14bfc31;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_byte = '0;
  logic         rx_valid = 1'b0, rx_frame = 1'b0;
  logic         golden_valid = 1'b0;
  logic [31:0]  golden_nonce = '0;
  logic         tx_ready = 1'b0;

  logic [255:0] core_midstate, core_data, x_midstate, x_data;
  logic [31:0]  core_nonce, job_id, x_nonce, x_job;
  logic         core_run, tx_valid, exhausted, fifo_overflow;
  logic         x_run, x_tx_valid, x_exh, x_ovf;
  logic [7:0]   tx_byte, x_tx_byte;

  always #5 clk = ~clk;

  miner_work_scheduler #(
    .NONCE_STEP (1),
    .FIFO_DEPTH (4),
    .PIPE_DEPTH (PIPE)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .rx_byte (rx_byte), .rx_valid (rx_valid), .rx_frame (rx_frame),
    .core_midstate (core_midstate), .core_data (core_data),
    .core_nonce (core_nonce), .core_run (core_run),
    .core_golden_valid (golden_valid), .core_golden_nonce (golden_nonce),
    .tx_byte (tx_byte), .tx_valid (tx_valid), .tx_ready (tx_ready),
    .job_id (job_id), .exhausted (exhausted), .fifo_overflow (fifo_overflow)
  );

  miner_work_scheduler #(
    .NONCE_STEP (XSTEP),
    .FIFO_DEPTH (4),
    .PIPE_DEPTH (PIPE)
  ) dut_x (
    .clk (clk), .rst_n (rst_n),
    .rx_byte (rx_byte), .rx_valid (rx_valid), .rx_frame (rx_frame),
    .core_midstate (x_midstate), .core_data (x_data),
    .core_nonce (x_nonce), .core_run (x_run),
    .core_golden_valid (golden_valid), .core_golden_nonce (golden_nonce),
    .tx_byte (x_tx_byte), .tx_valid (x_tx_valid), .tx_ready (tx_ready),
    .job_id (x_job), .exhausted (x_exh), .fifo_overflow (x_ovf)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];

  // Reference model state
  logic [31:0]  m_job = '0;
  logic [255:0] m_mid = '0, m_data = '0;
  int unsigned  m_commit_cyc = 0;
  bit           m_committed = 1'b0;

  // Advance one clock, logging any byte handshake that this edge completes
  task automatic tick();
    if (tx_valid && tx_ready) got_q.push_back(tx_byte);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Send bytes then a frame marker (optionally on the last byte); model the commit rule
  task automatic send_frame(input logic [7:0] b[$], input bit merge);
    int unsigned n;
    n = b.size();
    for (int unsigned i = 0; i < n; i++) begin
      rx_byte  = b[i];
      rx_valid = 1'b1;
      rx_frame = merge && (i == n - 1);
      tick();
    end
    rx_valid = 1'b0;
    if (!(merge && n > 0)) begin
      rx_frame = 1'b1;
      tick();
    end
    rx_frame = 1'b0;
    if (n == 64) begin
      for (int unsigned i = 0; i < 32; i++) m_mid  = {m_mid[247:0], b[i]};
      for (int unsigned i = 32; i < 64; i++) m_data = {m_data[247:0], b[i]};
      m_job        = m_job + 32'd1;
      m_commit_cyc = cyc;
      m_committed  = 1'b1;
    end
  endtask

  // Model a golden strobe about to be sampled: queue its record unless stale
  task automatic model_strobe(input logic [31:0] n);
    bit stale;
    logic [63:0] rec;
    stale = 1'b0;
`ifdef MINER_STALE_DROP_EN
    stale = m_committed && ((cyc - m_commit_cyc) < PIPE);
`endif
    if (!stale) begin
      rec = {m_job, n};
      for (int unsigned j = 0; j < 8; j++) exp_q.push_back(rec[8*j +: 8]);
    end
  endtask

  task automatic strobe(input logic [31:0] n);
    model_strobe(n);
    golden_valid = 1'b1;
    golden_nonce = n;
    tick();
    golden_valid = 1'b0;
  endtask

  task automatic wait_past_stale();
    while ((cyc - m_commit_cyc) < PIPE + 6) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({core_midstate, core_data} !== '0) begin
      failures++; $display("FAIL reset_work got=%h exp=0", {core_midstate, core_data});
    end
    checks++;
    if ({core_nonce, job_id} !== '0) begin
      failures++; $display("FAIL reset_nonce_job got=%h exp=0", {core_nonce, job_id});
    end
    checks++;
    if ({core_run, tx_valid, exhausted, fifo_overflow, tx_byte} !== '0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0", {core_run, tx_valid, exhausted, fifo_overflow, tx_byte});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_commit();
    logic [7:0]   b[$];
    logic [511:0] v;
    send_frame(b, 1'b0);
    checks++;
    if (job_id !== 32'd0 || core_run !== 1'b0) begin
      failures++; $display("FAIL empty_marker got job=%0d run=%b exp job=0 run=0", job_id, core_run);
    end
    v = {MID, DAT};
    for (int unsigned i = 0; i < 64; i++) b.push_back(v[511 - 8*i -: 8]);
    send_frame(b, 1'b0);
    checks++;
    if (core_midstate !== MID || core_midstate !== m_mid) begin
      failures++; $display("FAIL commit_midstate got=%h exp=%h", core_midstate, MID);
    end
    checks++;
    if (core_data !== DAT) begin
      failures++; $display("FAIL commit_data got=%h exp=%h", core_data, DAT);
    end
    checks++;
    if (job_id !== 32'd1 || core_run !== 1'b1 || core_nonce !== 32'd0) begin
      failures++; $display("FAIL commit_start got job=%0d run=%b nonce=%h exp job=1 run=1 nonce=0", job_id, core_run, core_nonce);
    end
    for (int unsigned k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (core_nonce !== 32'(k)) begin
        failures++; $display("FAIL nonce_seq got=%h exp=%h", core_nonce, 32'(k));
      end
    end
  endtask

  task automatic test_golden();
    logic [63:0] act;
    int unsigned t;
    wait_past_stale();
    tx_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    strobe(32'h01D00BDC);
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++; $display("FAIL latency_early got tx_valid=%b exp=0", tx_valid);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'hDC) begin
      failures++; $display("FAIL latency_2clk got valid=%b byte=%h exp valid=1 byte=dc", tx_valid, tx_byte);
    end
    t = 0;
    while (got_q.size() < 8 && t < 30) begin tick(); t++; end
    act = '0;
    for (int unsigned j = 0; j < 8 && j < got_q.size(); j++) act[8*j +: 8] = got_q[j];
    checks++;
    if (got_q.size() != 8 || act !== 64'h00000001_01D00BDC) begin
      failures++; $display("FAIL golden_record got n=%0d rec=%h exp n=8 rec=0000000101d00bdc", got_q.size(), act);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_bad_frames();
    logic [7:0] b[$];
    int unsigned lens[3] = '{63, 66, 65};
    for (int unsigned f = 0; f < 3; f++) begin
      b.delete();
      for (int unsigned i = 0; i < lens[f]; i++) b.push_back(8'($urandom));
      send_frame(b, f == 2);
      checks++;
      if (job_id !== m_job || core_midstate !== m_mid || core_nonce !== 32'(cyc - m_commit_cyc)) begin
        failures++; $display("FAIL bad_frame_%0d got job=%0d nonce=%h exp job=%0d nonce=%h",
                             lens[f], job_id, core_nonce, m_job, 32'(cyc - m_commit_cyc));
      end
    end
  endtask

  task automatic test_exhaust();
    logic [7:0]  b[$];
    int unsigned k;
    logic [31:0] en;
    for (int unsigned i = 0; i < 64; i++) b.push_back(8'($urandom));
    send_frame(b, 1'b0);
    for (int unsigned s = 0; s < 7; s++) begin
      k  = cyc - m_commit_cyc;
      en = (k < 4) ? 32'(k * XSTEP) : 32'(3 * XSTEP);
      checks++;
      if (x_nonce !== en || x_run !== (k < 4) || x_exh !== (k >= 4)) begin
        failures++; $display("FAIL exhaust_k%0d got nonce=%h run=%b exh=%b exp nonce=%h run=%b exh=%b",
                             k, x_nonce, x_run, x_exh, en, k < 4, k >= 4);
      end
      tick();
    end
    b.delete();
    for (int unsigned i = 0; i < 64; i++) b.push_back(8'($urandom));
    send_frame(b, 1'b1);
    checks++;
    if (x_nonce !== 32'd0 || x_run !== 1'b1 || x_exh !== 1'b0 || x_job !== m_job) begin
      failures++; $display("FAIL exhaust_restart got nonce=%h run=%b exh=%b job=%0d exp nonce=0 run=1 exh=0 job=%0d",
                           x_nonce, x_run, x_exh, x_job, m_job);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] n[6];
    logic [63:0] act;
    int unsigned t;
    wait_past_stale();
    tx_ready = 1'b0;
    got_q.delete();
    for (int unsigned i = 0; i < 6; i++) n[i] = $urandom;
    for (int unsigned i = 0; i < 6; i++) begin
      golden_valid = 1'b1;
      golden_nonce = n[i];
      tick();
      if (i == 4) begin
        checks++;
        if (fifo_overflow !== 1'b0) begin
          failures++; $display("FAIL ovf_early got=%b exp=0", fifo_overflow);
        end
      end
    end
    golden_valid = 1'b0;
    checks++;
    if (fifo_overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_set got=%b exp=1", fifo_overflow);
    end
    repeat (3) tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== n[0][7:0]) begin
      failures++; $display("FAIL backpressure_hold got valid=%b byte=%h exp valid=1 byte=%h", tx_valid, tx_byte, n[0][7:0]);
    end
    tx_ready = 1'b1;
    t = 0;
    while (t < 120) begin tick(); t++; end
    checks++;
    if (got_q.size() != 40) begin
      failures++; $display("FAIL ovf_count got=%0d exp=40", got_q.size());
    end
    for (int unsigned r = 0; r < 5; r++) begin
      act = '0;
      for (int unsigned j = 0; j < 8; j++)
        if (8*r + j < got_q.size()) act[8*j +: 8] = got_q[8*r + j];
      checks++;
      if (act !== {m_job, n[r]}) begin
        failures++; $display("FAIL ovf_rec%0d got=%h exp=%h", r, act, {m_job, n[r]});
      end
    end
    checks++;
    if (fifo_overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_sticky got=%b exp=1", fifo_overflow);
    end
    got_q.delete();
  endtask

  task automatic test_stale();
    logic [7:0] b[$];
    for (int unsigned i = 0; i < 64; i++) b.push_back(8'($urandom));
    send_frame(b, 1'b0);
    tx_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    while ((cyc - m_commit_cyc) < 9) tick();
    strobe($urandom);
    repeat (30) tick();
    checks++;
    if (got_q != exp_q) begin
      failures++; $display("FAIL stale_window got n=%0d exp n=%0d", got_q.size(), exp_q.size());
    end
    got_q.delete();
    exp_q.delete();
    wait_past_stale();
    strobe($urandom);
    repeat (30) tick();
    checks++;
    if (got_q.size() != 8 || got_q != exp_q) begin
      failures++; $display("FAIL post_stale got n=%0d exp n=8", got_q.size());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0]  b[$];
    int unsigned lens[7] = '{62, 63, 64, 64, 64, 65, 66};
    int unsigned t;
    for (int unsigned it = 0; it < 20; it++) begin
      b.delete();
      for (int unsigned i = 0; i < lens[$urandom_range(0, 6)]; i++) b.push_back(8'($urandom));
      send_frame(b, 1'($urandom_range(0, 1)));
      checks++;
      if (job_id !== m_job || core_midstate !== m_mid || core_data !== m_data ||
          core_nonce !== 32'(cyc - m_commit_cyc)) begin
        failures++; $display("FAIL rand_frame it=%0d len=%0d got job=%0d nonce=%h exp job=%0d nonce=%h",
                             it, b.size(), job_id, core_nonce, m_job, 32'(cyc - m_commit_cyc));
      end
      got_q.delete();
      exp_q.delete();
      t = $urandom_range(0, 80);
      repeat (t) begin tx_ready = ($urandom_range(0, 9) < 7); tick(); end
      strobe($urandom);
      t = 0;
      while ((got_q.size() < exp_q.size() || tx_valid) && t < 200) begin
        tx_ready = ($urandom_range(0, 9) < 7);
        tick();
        t++;
      end
      repeat (4) tick();
      checks++;
      if (got_q != exp_q) begin
        failures++; $display("FAIL rand_result it=%0d got n=%0d exp n=%0d", it, got_q.size(), exp_q.size());
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_record();
    wait_past_stale();
    tx_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) strobe($urandom);
    tx_ready = 1'b1;
    repeat (2) tick();
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b1) begin
      failures++; $display("FAIL mid_record_setup got tx_valid=%b exp=1", tx_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (tx_valid !== 1'b0 || job_id !== 32'd0 || core_run !== 1'b0 || core_midstate !== '0) begin
      failures++; $display("FAIL reset_mid got valid=%b job=%0d run=%b exp valid=0 job=0 run=0", tx_valid, job_id, core_run);
    end
    rst_n = 1'b1;
    m_job = '0; m_mid = '0; m_data = '0; m_committed = 1'b0;
    got_q.delete();
    exp_q.delete();
    tx_ready = 1'b1;
    repeat (30) tick();
    checks++;
    if (got_q.size() != 0 || tx_valid !== 1'b0 || fifo_overflow !== 1'b0) begin
      failures++; $display("FAIL reset_fifo_empty got bytes=%0d valid=%b ovf=%b exp 0 0 0", got_q.size(), tx_valid, fifo_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_golden();
    test_bad_frames();
    test_exhaust();
    test_overflow();
    test_stale();
    test_random();
    test_reset_mid_record();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/miner_work_scheduler.md
Name: miner_work_scheduler

Overview:
- Sits between the bitbang byte receiver/transmitter and the SHA-256 hash core inside fpgaminer_top.
- Assembles 64-byte work frames (32 B midstate, then 32 B data) into a shadow buffer and commits them atomically to the core.
- Sequences the nonce counter and stops when the nonce space is exhausted.
- Queues golden nonces, tagged with a job id, and serialises them as 8-byte result records for the transmitter.

Parameters:
- NONCE_STEP, 1: nonce increment per clk while hashing; power of two.
- FIFO_DEPTH, 4: result FIFO entries; power of two.
- PIPE_DEPTH, 64: hash core latency in clk; sets the stale window.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- rx_byte  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_byte valid.
- rx_frame  in  1  one-cycle strobe, frame boundary (RxTxR).
- core_midstate  out  256  committed midstate, first byte received in [255:248].
- core_data  out  256  committed data, first byte in [255:248].
- core_nonce  out  32  nonce presented to the core this cycle.
- core_run  out  1  core_nonce valid.
- core_golden_valid  in  1  one-cycle strobe, golden nonce found.
- core_golden_nonce  in  32  nonce that produced the golden hash.
- tx_byte  out  8  result byte.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  transmitter accepts tx_byte.
- job_id  out  32  id of the committed work.
- exhausted  out  1  nonce space finished for the current job.
- fifo_overflow  out  1  sticky; a golden nonce was dropped.

Behaviour:
- Reset values:
  - core_midstate, core_data, core_nonce, job_id: 0.
  - core_run, tx_valid, exhausted, fifo_overflow: 0.
  - tx_byte: 0.
  - FIFO empty, byte counter 0, FSM in IDLE.
- Reset mid-operation abandons any partial frame and any partly sent record.
- Receive:
  - Each rx_valid shifts rx_byte into a 512-bit shadow buffer, MSB first, and increments a 7-bit byte counter.
  - The counter saturates at 65; a count of 65 marks overflow.
- rx_frame handling:
  - Counter == 64: commit. Shadow[511:256] goes to core_midstate, shadow[255:0] to core_data, job_id increments.
  - Any other count, including 0: discard, no state change.
  - In both cases the counter clears.
  - If rx_valid and rx_frame are asserted in the same cycle, the byte is counted first.
- Hashing continues on the committed work while the next frame loads into the shadow buffer.
- FSM states:
  - IDLE -> HASH on commit.
  - HASH -> HASH on commit, which restarts the nonce.
  - HASH -> EXHAUSTED after the last nonce is issued.
  - EXHAUSTED -> HASH on commit.
- Nonce sequencing:
  - The cycle after a commit: core_nonce = 0, core_run = 1.
  - Each following HASH cycle adds NONCE_STEP to core_nonce.
  - When the 32-bit addition would carry out, the current value is the last one issued. Next cycle: core_run = 0, exhausted = 1, core_nonce holds.
  - A commit clears exhausted.
- Result capture:
  - core_golden_valid pushes {core_golden_nonce, job_id} into the FIFO.
  - FIFO full: the entry is dropped and fifo_overflow is set. It clears only on reset.
  - A push and a pop in the same cycle are both honoured when the FIFO is full.
- Serialiser:
  - Pops one entry and sends 8 bytes: nonce[7:0], [15:8], [23:16], [31:24], then job_id bytes, LSB first.
  - tx_valid stays high with tx_byte stable until tx_ready is sampled high; each handshake advances one byte.
  - The next entry is popped the cycle after the 8th handshake.
- Latency from golden strobe to tx_valid, FIFO empty and serialiser idle: 2 clk.

Optional Feature:
- Macro: MINER_STALE_DROP_EN.
- Defined: for PIPE_DEPTH clk after each commit, golden strobes are discarded. They belong to the previous job and are neither queued nor counted as overflow.
- Undefined: such strobes are queued, tagged with the new job_id.

Decomposition:
- Package miner_pkg:
  - WORK_BYTES = 64, RESULT_BYTES = 8.
  - FSM state enum {IDLE, HASH, EXHAUSTED}.
  - Result record typedef {nonce[31:0], job[31:0]}.
- Sub-module result_fifo: synchronous FIFO of width 64 and depth FIFO_DEPTH, with full/empty flags. Instantiated once.

Test Plan:
- Send frame marker, then 64 bytes (midstate 2b3f8126…2619c0b5, data 00…80000000_00000000_39f3001b6b7b8d4dc14bfc31), then frame marker -> core_midstate/core_data match bit-exact; job_id = 1; core_nonce = 0 one cycle after commit, then 1, 2, 3…
- Golden strobe with nonce 30411740 (0x01D00BDC), tx_ready always high -> bytes DC 0B D0 01 01 00 00 00.
- Frame of 63 bytes, then marker -> no commit; job_id and core_nonce sequence unaffected. Same check with 65 bytes.
- Force core_nonce to 0xFFFFFFFE with NONCE_STEP = 1 -> 0xFFFFFFFF issued, then core_run = 0 and exhausted = 1. A new commit restarts at 0.
- 6 golden strobes with FIFO_DEPTH = 4 and tx_ready low -> fifo_overflow = 1. Releasing tx_ready yields records for the first 5 strobes: one is popped into the serialiser, 4 are queued.
- Golden strobe 10 clk after a commit -> with MINER_STALE_DROP_EN no record is sent; without it a record is sent with the new job_id. Also assert rst_n low mid-record -> tx_valid = 0 the next cycle and the FIFO is empty.
